// File: rtl/ccip_interface_pipe_n.sv
// CCI-P boundary register slice between the FIU and the AFU.
// Configurable Rx/Tx depth, stretched soft reset, almFull overrun monitor.
package ccip_if_pkg;

  typedef struct packed {
    logic [27:0]  hdr;
    logic [511:0] data;
    logic         rspValid;
    logic         mmioRdValid;
    logic         mmioWrValid;
  } t_if_ccip_c0_Rx;

  typedef struct packed {
    logic [27:0] hdr;
    logic        rspValid;
  } t_if_ccip_c1_Rx;

  typedef struct packed {
    logic           c0TxAlmFull;
    logic           c1TxAlmFull;
    t_if_ccip_c0_Rx c0;
    t_if_ccip_c1_Rx c1;
  } t_if_ccip_Rx;

  typedef struct packed {
    logic [73:0] hdr;
    logic        valid;
  } t_if_ccip_c0_Tx;

  typedef struct packed {
    logic [79:0]  hdr;
    logic [511:0] data;
    logic         valid;
  } t_if_ccip_c1_Tx;

  typedef struct packed {
    logic [8:0]  hdr;
    logic [63:0] data;
    logic        mmioRdValid;
  } t_if_ccip_c2_Tx;

  typedef struct packed {
    t_if_ccip_c0_Tx c0;
    t_if_ccip_c1_Tx c1;
    t_if_ccip_c2_Tx c2;
  } t_if_ccip_Tx;

endpackage

module ccip_interface_pipe_n
  import ccip_if_pkg::*;
#(
  parameter int RX_STAGES      = 1,
  parameter int TX_STAGES      = 1,
  parameter int RST_STAGES     = 2,
  parameter int RST_STRETCH    = 16,
  parameter int ALMFULL_BUDGET = 8
) (
  input  logic        pClk,
  input  logic        pck_cp2af_softReset_T0,
  input  logic [1:0]  pck_cp2af_pwrState_T0,
  input  logic        pck_cp2af_error_T0,
  input  t_if_ccip_Rx pck_cp2af_sRx_T0,
  input  t_if_ccip_Tx pck_af2cp_sTx_T0,
  output logic        pck_cp2af_softReset_Tn,
  output logic [1:0]  pck_cp2af_pwrState_Tn,
  output logic        pck_cp2af_error_Tn,
  output t_if_ccip_Rx pck_cp2af_sRx_Tn,
  output t_if_ccip_Tx pck_af2cp_sTx_Tn,
  output logic [1:0]  almfull_overrun
);

  localparam logic [7:0] RST_RELOAD = 8'(RST_STRETCH - 1);
  localparam logic [3:0] OVF_BUDGET = 4'(ALMFULL_BUDGET);
  localparam logic [3:0] OVF_MAX    = 4'(ALMFULL_BUDGET + 1);

  logic rst;
  assign rst = pck_cp2af_softReset_T0;

  // Rx / pwrState / error delay line
  t_if_ccip_Rx rx_d  [RX_STAGES];
  t_if_ccip_Rx rx_q  [RX_STAGES];
  logic [1:0]  pwr_d [RX_STAGES];
  logic [1:0]  pwr_q [RX_STAGES];
  logic        err_d [RX_STAGES];
  logic        err_q [RX_STAGES];

  always_comb begin
    rx_d[0]  = pck_cp2af_sRx_T0;
    pwr_d[0] = pck_cp2af_pwrState_T0;
    err_d[0] = pck_cp2af_error_T0;
    for (int i = 1; i < RX_STAGES; i++) begin
      rx_d[i]  = rx_q[i-1];
      pwr_d[i] = pwr_q[i-1];
      err_d[i] = err_q[i-1];
    end
  end

  always_ff @(posedge pClk) begin
    rx_q  <= rx_d;
    pwr_q <= pwr_d;
    err_q <= err_d;
    if (rst) begin
      for (int i = 0; i < RX_STAGES; i++) begin
        rx_q[i].c0TxAlmFull    <= 1'b1;
        rx_q[i].c1TxAlmFull    <= 1'b1;
        rx_q[i].c0.rspValid    <= 1'b0;
        rx_q[i].c0.mmioRdValid <= 1'b0;
        rx_q[i].c0.mmioWrValid <= 1'b0;
        rx_q[i].c1.rspValid    <= 1'b0;
        pwr_q[i]               <= 2'b00;
        err_q[i]               <= 1'b0;
      end
    end
  end

  // Tx delay line
  t_if_ccip_Tx tx_d [TX_STAGES];
  t_if_ccip_Tx tx_q [TX_STAGES];

  always_comb begin
    tx_d[0] = pck_af2cp_sTx_T0;
    for (int i = 1; i < TX_STAGES; i++) begin
      tx_d[i] = tx_q[i-1];
    end
  end

  always_ff @(posedge pClk) begin
    tx_q <= tx_d;
    if (rst) begin
      for (int i = 0; i < TX_STAGES; i++) begin
        tx_q[i].c0.valid       <= 1'b0;
        tx_q[i].c1.valid       <= 1'b0;
        tx_q[i].c2.mmioRdValid <= 1'b0;
      end
    end
  end

  // Reset stretcher. rcnt follows the delayed reset only, so a new
  // input pulse can never cut a running window short.
  logic [RST_STAGES-1:0] rpipe_d;
  logic [RST_STAGES-1:0] rpipe_q;
  logic [7:0]            rcnt_d;
  logic [7:0]            rcnt_q;
  logic                  rlast;
  logic                  rst_tn;

  always_comb begin
    rpipe_d = RST_STAGES'({rpipe_q, rst});
    rlast   = rpipe_q[RST_STAGES-1];
    rcnt_d  = rcnt_q;
    if (rlast) begin
      rcnt_d = RST_RELOAD;
    end else if (rcnt_q != 8'd0) begin
      rcnt_d = rcnt_q - 8'd1;
    end
    rst_tn = rlast | (rcnt_q != 8'd0);
  end

  always_ff @(posedge pClk) begin
    rpipe_q <= rpipe_d;
    rcnt_q  <= rcnt_d;
  end

  // Overrun monitor: Tx seen at the FIU against the FIU's own almFull
  logic [3:0] ovf_d [2];
  logic [3:0] ovf_q [2];
  logic [1:0] ovr_d;
  logic [1:0] ovr_q;
  logic [1:0] af_in;
  logic [1:0] tx_v;

  always_comb begin
    af_in = {pck_cp2af_sRx_T0.c1TxAlmFull,
             pck_cp2af_sRx_T0.c0TxAlmFull};
    tx_v  = {tx_q[TX_STAGES-1].c1.valid,
             tx_q[TX_STAGES-1].c0.valid};
    ovr_d = ovr_q;
    for (int n = 0; n < 2; n++) begin
      ovf_d[n] = ovf_q[n];
      if (!af_in[n]) begin
        ovf_d[n] = 4'd0;
      end else if (tx_v[n]) begin
        if (ovf_q[n] >= OVF_BUDGET) begin
          ovr_d[n] = 1'b1;
        end
        if (ovf_q[n] < OVF_MAX) begin
          ovf_d[n] = ovf_q[n] + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge pClk) begin
    if (rst) begin
      ovf_q[0] <= 4'd0;
      ovf_q[1] <= 4'd0;
      ovr_q    <= 2'b00;
    end else begin
      ovf_q    <= ovf_d;
      ovr_q    <= ovr_d;
    end
  end

  // AFU sees full for as long as it is held in reset
  always_comb begin
    pck_cp2af_sRx_Tn = rx_q[RX_STAGES-1];
    pck_cp2af_sRx_Tn.c0TxAlmFull =
      rx_q[RX_STAGES-1].c0TxAlmFull | rst_tn;
    pck_cp2af_sRx_Tn.c1TxAlmFull =
      rx_q[RX_STAGES-1].c1TxAlmFull | rst_tn;
  end

  assign pck_cp2af_pwrState_Tn  = pwr_q[RX_STAGES-1];
  assign pck_cp2af_error_Tn     = err_q[RX_STAGES-1];
  assign pck_af2cp_sTx_Tn       = tx_q[TX_STAGES-1];
  assign pck_cp2af_softReset_Tn = rst_tn;
  assign almfull_overrun        = ovr_q;

endmodule
